// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder reused LSB-first over WIDTH cycles,
// with registered sum/cout/ovf published on the final bit.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c, last;

  // The single shared full adder
  assign fa_s = a_q[0] ^ b_q[0] ^ c_q;
  assign fa_c = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          c_d     = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        sh_d  = {fa_s, sh_q[WIDTH-1:1]};
        c_d   = fa_c;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          // c_q here is the carry into the MSB
          sum_d   = {fa_s, sh_q[WIDTH-1:1]};
          cout_d  = fa_c;
          ovf_d   = c_q ^ fa_c;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin one addition; sampled on rising clk.
REQ-005 SHALL have port: a_in  input  WIDTH  operand A; captured only when a start is accepted.
REQ-006 SHALL have port: b_in  input  WIDTH  operand B; captured only when a start is accepted.
REQ-007 SHALL have port: cin  input  1  carry-in; captured only when a start is accepted.
REQ-008 SHALL have port: busy  output  1  high while bits are being processed.
REQ-009 SHALL have port: done  output  1  one-cycle pulse marking a valid result.
REQ-010 SHALL have port: sum  output  WIDTH  result of A+B+cin modulo 2^WIDTH.
REQ-011 SHALL have port: cout  output  1  carry out of bit WIDTH-1.
REQ-012 SHALL have port: ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

Function
REQ-013 SHALL contain exactly one 1-bit full-adder datapath (sum = a^b^c, carry = a&b | c&(a^b)), reused once per bit.
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 IDLE: start=1 at edge E0 SHALL load A, B shift registers from a_in, b_in, load carry flop from cin, clear the bit counter, and enter RUN.
REQ-016 RUN: each edge SHALL add A[0], B[0] and the carry flop, shift the sum bit into the internal sum shift register at MSB, shift A and B right by one, update the carry flop, and increment the counter.
REQ-017 Bits SHALL be processed LSB first; bit i SHALL be processed at edge E(i+1).
REQ-018 At edge E(WIDTH), the last bit edge, the FSM SHALL enter DONE and SHALL register sum, cout and ovf from the final bit; ovf SHALL use the carry into bit WIDTH-1.
REQ-019 busy SHALL be 1 exactly while in RUN, i.e. for WIDTH cycles after E0.
REQ-020 done SHALL be 1 exactly while in DONE, for one cycle after E(WIDTH); DONE SHALL return to IDLE on the next edge.
REQ-021 sum, cout and ovf SHALL change only at E(WIDTH) and SHALL hold their values until the next completion or reset.
REQ-022 start SHALL be ignored in RUN; operands and the carry SHALL be unaffected.
REQ-023 start=1 in DONE SHALL be accepted like IDLE (load and enter RUN), so back-to-back operations run with no idle cycle.
REQ-024 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap within one operation.
REQ-025 Changes on a_in, b_in or cin after E0 SHALL NOT affect the operation in progress.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for a clock edge, force state IDLE, and drive busy=0, done=0, sum=0, cout=0, ovf=0; it SHALL also clear the carry flop, counter and shift registers.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow for that operation.
REQ-028 start SHALL be ignored at any edge where rst=1; after release, the first start edge SHALL behave as REQ-015.

Verification (WIDTH=8)
REQ-029 a=0x0F, b=0x01, cin=0, start at E0 -> busy high for 8 cycles, done at E8 only, sum=0x10, cout=0, ovf=0.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
REQ-031 Pulse start at E3 with a=0x55, b=0x55 during an operation on 0x0A+0x05 -> result is sum=0x0F at E8, and no second done follows.
REQ-032 Hold start=1 continuously with 0x01+0x01 then 0x80+0x80 -> done pulses 9 cycles apart: sum=0x02, cout=0; then sum=0x00, cout=1, ovf=1.
REQ-033 Assert rst asynchronously between E4 and E5 of 0xAA+0x55 -> outputs are 0 immediately; no done pulse; the next 0x03+0x04 gives sum=0x07.
REQ-034 Random a, b, cin over 1000 operations with random start gaps -> {cout,sum} equals a+b+cin, and ovf matches the signed-overflow reference model.
